// File: rtl/aes_inv_cipher.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher -- iterative AES-128 inverse cipher (FIPS-197 InvCipher).
//
// Recovers a 128-bit plaintext block from a ciphertext block and the cipher
// key, one round per clock. Round keys are produced on the fly: first the
// key is run forward to K10, then each decrypt round steps it back by one.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request, sampled only while idle (busy=0)
//   Cipher_Text  ciphertext, byte 0 = bits[127:120], sampled with start
//   Key          cipher key (round key 0), same byte order, sampled with start
//   Plain_Text   decrypted block, same byte order
//   busy         high from the edge after start is accepted until the result edge
//   done         one-cycle pulse, Plain_Text valid
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// block is idle. busy then stays high for 20 cycles; done pulses for exactly
// one cycle together with the result. start while busy is ignored (no queue).
//
// Also contains the byte S-box leaves aes_sbox and aes_inv_sbox, computed
// arithmetically (GF(2^8) inverse plus affine map) instead of as tables.
// ---------------------------------------------------------------------------

// Forward S-box: affine(inverse(x)).
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// Inverse S-box: inverse(inverse_affine(x)).
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] pre;

    always_comb begin
        pre      = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]}
                 ^ {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
        out_byte = gf_inv(pre);
    end
endmodule

module aes_inv_cipher #(
    parameter int NR       = 10,
    parameter bit HOLD_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] Cipher_Text,
    input  logic [127:0] Key,
    output logic [127:0] Plain_Text,
    output logic         busy,
    output logic         done
);
    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes_inv_cipher: only NR=10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KEYEXP = 2'd1,
        S_ROUND  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   rcnt_q,  rcnt_d;
    logic [127:0] key_q,   key_d;
    logic [127:0] data_q,  data_d;
    logic [127:0] pt_q,    pt_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Key schedule. Forward and inverse steps both need
    // SubWord(RotWord(w3)) ^ Rcon; they differ only in which w3 is used:
    // the current last word going forward, v3^v2 going backward. One set
    // of four S-boxes serves both directions.
    // ------------------------------------------------------------------
    logic [31:0]  v0, v1, v2, v3;
    logic [31:0]  sw_in, sw_rot, sw_out, rcon_word;
    logic [3:0]   rcon_idx;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] fwd_key, inv_key;

    assign v0 = key_q[127:96];
    assign v1 = key_q[95:64];
    assign v2 = key_q[63:32];
    assign v3 = key_q[31:0];

    always_comb begin
        if (state_q == S_ROUND) begin
            sw_in    = v3 ^ v2;
            rcon_idx = rcnt_q + 4'd1;
        end else begin
            sw_in    = v3;
            rcon_idx = rcnt_q;
        end
    end

    assign sw_rot    = {sw_in[23:0], sw_in[31:24]};
    assign rcon_word = {rcon(rcon_idx), 24'h000000};

    for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
        aes_sbox u_sbox (
            .in_byte  (sw_rot[8*g +: 8]),
            .out_byte (sw_out[8*g +: 8])
        );
    end

    assign f0      = v0 ^ sw_out ^ rcon_word;
    assign f1      = v1 ^ f0;
    assign f2      = v2 ^ f1;
    assign f3      = v3 ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
    assign inv_key = {v0 ^ sw_out ^ rcon_word, v1 ^ v0, v2 ^ v1, v3 ^ v2};

    // ------------------------------------------------------------------
    // Data round: InvShiftRows -> InvSubBytes -> AddRoundKey(K(r)) ->
    // InvMixColumns (skipped in the last round). Byte k of the block sits
    // at row k%4, column k/4.
    // ------------------------------------------------------------------
    logic [7:0]   sh_b  [16];
    logic [7:0]   isb_b [16];
    logic [127:0] ark, mix;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                // Row r rotates right by r: new column c takes old column c-r.
                sh_b[4*c + r] = data_q[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
        aes_inv_sbox u_isbox (
            .in_byte  (sh_b[g]),
            .out_byte (isb_b[g])
        );
    end

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            ark[127 - 8*k -: 8] = isb_b[k] ^ inv_key[127 - 8*k -: 8];
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mix[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        key_d   = key_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // With HOLD_OUT=0 the result is visible only in the done cycle.
        pt_d    = HOLD_OUT ? pt_q : 128'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = Cipher_Text;
                    key_d   = Key;
                    rcnt_d  = 4'd1;
                    busy_d  = 1'b1;
                    state_d = S_KEYEXP;
                end
            end
            S_KEYEXP: begin
                key_d  = fwd_key;
                rcnt_d = rcnt_q + 4'd1;
                if (rcnt_q == LAST_RND) begin
                    // K10 reached: apply the initial AddRoundKey.
                    data_d  = data_q ^ fwd_key;
                    rcnt_d  = LAST_RND - 4'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                key_d = inv_key;
                if (rcnt_q != 4'd0) begin
                    data_d = mix;
                    rcnt_d = rcnt_q - 4'd1;
                end else begin
                    data_d  = ark;
                    pt_d    = ark;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                rcnt_d  = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rcnt_q  <= 4'd0;
            key_q   <= 128'd0;
            data_q  <= 128'd0;
            pt_q    <= 128'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            key_q   <= key_d;
            data_q  <= data_d;
            pt_q    <= pt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Plain_Text = pt_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher -- directed and random checks of aes_inv_cipher.
// Expected plaintexts go into exp_q when a block is launched; a monitor pops
// and compares them whenever done is seen. Random blocks are produced by an
// AES-128 forward-cipher model in this file.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] Cipher_Text;
    logic [127:0] Key;
    logic [127:0] Plain_Text;
    logic         busy;
    logic         done;

    int           total = 0;
    int           bad   = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   sbox_t[256];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_cipher dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Cipher_Text (Cipher_Text),
        .Key         (Key),
        .Plain_Text  (Plain_Text),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- forward AES model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] cst;
        logic [7:0] b;
        cst = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            for (int i = 0; i < 8; i++) begin
                b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ cst[i];
            end
            sbox_t[a] = b;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        logic [127:0] k;
        logic [31:0]  tmp, w0, w1, w2, w3;
        logic [7:0]   rc;
        blk = pt ^ key;
        k   = key;
        rc  = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[blk[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = s[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]     = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c + 1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c + 2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c + 3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            tmp = {sbox_t[k[23:16]], sbox_t[k[15:8]], sbox_t[k[7:0]], sbox_t[k[31:24]]}
                ^ {rc, 24'h000000};
            w0 = k[127:96] ^ tmp;
            w1 = k[95:64] ^ w0;
            w2 = k[63:32] ^ w1;
            w3 = k[31:0] ^ w2;
            k  = {w0, w1, w2, w3};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i] ^ k[127 - 8*i -: 8];
        end
        return blk;
    endfunction

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic launch(input logic [127:0] ct, input logic [127:0] k);
        Cipher_Text = ct;
        Key         = k;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        Cipher_Text = {$urandom, $urandom, $urandom, $urandom};
        Key         = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            check("done_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) check("plain_text", Plain_Text, exp_q.pop_front());
            check("busy_low_at_done", 128'(busy), 128'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int           n;
        logic [127:0] pt;
        logic [127:0] k;

        rst         = 1'b1;
        start       = 1'b0;
        Cipher_Text = 128'd0;
        Key         = 128'd0;
        build_sbox();

        @(negedge clk);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_pt", Plain_Text, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: nothing moves without start.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_busy", 128'(busy), 128'd0);
            check("idle_done", 128'(done), 128'd0);
            check("idle_pt", Plain_Text, 128'd0);
        end

        // FIPS-197 C.1 with exact latency.
        exp_q.push_back(PT1);
        launch(CT1, K1);
        check("v1_busy", 128'(busy), 128'd1);
        wait_done(n);
        check("v1_latency", 128'(n), 128'd20);
        @(negedge clk);
        check("v1_done_one_cycle", 128'(done), 128'd0);
        check("v1_pt_hold", Plain_Text, PT1);

        // FIPS-197 appendix B.
        exp_q.push_back(PT2);
        launch(CT2, K2);
        wait_done(n);
        check("v2_latency", 128'(n), 128'd20);
        repeat (3) @(negedge clk);
        check("v2_pt_hold", Plain_Text, PT2);

        // start held high with garbage inputs while busy; restart in the done cycle.
        exp_q.push_back(PT1);
        Cipher_Text = CT1;
        Key         = K1;
        start       = 1'b1;
        @(negedge clk);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            Cipher_Text = {$urandom, $urandom, $urandom, $urandom};
            Key         = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n++;
        end
        check("held_start_latency", 128'(n), 128'd20);
        exp_q.push_back(PT2);
        Cipher_Text = CT2;
        Key         = K2;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted_busy", 128'(busy), 128'd1);
        wait_done(n);
        check("b2b_period", 128'(n + 1), 128'd21);

        // Asynchronous reset mid-run aborts the operation.
        launch(CT1, K1);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_pt", Plain_Text, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("abort_no_done", 128'(n), 128'd0);
        exp_q.push_back(PT2);
        launch(CT2, K2);
        wait_done(n);
        check("after_abort_latency", 128'(n), 128'd20);

        // Round trip against the forward model.
        for (int i = 0; i < 100; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(pt);
            launch(encrypt(pt, k), k);
            wait_done(n);
            check("rt_latency", 128'(n), 128'd20);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
